// File: rtl/beam_ctrl_pkg.sv
// Shared types and helpers for the beam threshold control path.
package beam_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UPDATE = 2'd2,
    SETTLE = 2'd3
  } bts_state_t;

  localparam int DEFAULT_THRESH_BITS = 18;

  // Beam index width; never zero, so a single-beam build still has a legal index bus.
  function automatic int BEAM_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beam_threshold_sequencer_if.sv
// Control-side write/commit bus plus the datapath-facing threshold load outputs.
interface beam_threshold_sequencer_if
  import beam_ctrl_pkg::*;
#(
  parameter int NBEAMS      = 4,
  parameter int THRESH_BITS = DEFAULT_THRESH_BITS
);
  localparam int IDX_W = BEAM_IDX_W(NBEAMS);

  // commit_valid_i/commit_ready_o: a commit transfers on any rising edge where both
  // are high; valid may be held, ready is high only while the sequencer is idle.
  logic                   wr_en_i;
  logic [IDX_W-1:0]       wr_beam_i;
  logic [THRESH_BITS-1:0] wr_thresh_i;
  logic                   commit_valid_i;
  logic                   commit_ready_o;
  logic                   busy_o;
  logic                   done_o;
  logic [NBEAMS-1:0]      dirty_o;
  logic [THRESH_BITS-1:0] thresh_o;
  logic [NBEAMS-1:0]      thresh_ce_o;
  logic                   update_o;
  bts_state_t             state_dbg;

  modport master (
    output wr_en_i, wr_beam_i, wr_thresh_i, commit_valid_i,
    input  commit_ready_o, busy_o, done_o, dirty_o, thresh_o, thresh_ce_o, update_o,
    input  state_dbg
  );

  modport slave (
    input  wr_en_i, wr_beam_i, wr_thresh_i, commit_valid_i,
    output commit_ready_o, busy_o, done_o, dirty_o, thresh_o, thresh_ce_o, update_o,
    output state_dbg
  );

endinterface

// File: rtl/beam_threshold_sequencer.sv
// Shadow threshold file with commit-triggered, one-beam-per-cycle load into beam_alignment,
// followed by a single atomic update pulse.
module beam_threshold_sequencer
  import beam_ctrl_pkg::*;
#(
  parameter int                     NBEAMS       = 4,
  parameter int                     THRESH_BITS  = DEFAULT_THRESH_BITS,
  parameter logic [THRESH_BITS-1:0] RESET_THRESH = '1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  beam_threshold_sequencer_if.slave bus
);

  localparam int               IDX_W    = BEAM_IDX_W(NBEAMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEAMS - 1);

  bts_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   init_q;
  logic [THRESH_BITS-1:0] shadow_q [NBEAMS];
  logic [THRESH_BITS-1:0] snap_q   [NBEAMS];
  logic [NBEAMS-1:0]      dirty_q, dirty_d, wr_hit;
  logic [THRESH_BITS-1:0] thresh_q, thresh_d;
  logic [NBEAMS-1:0]      ce_q, ce_d;
  logic                   update_q, update_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic                   wr_valid;
  logic                   accept;
  logic                   start;

  assign wr_valid = bus.wr_en_i && (int'(bus.wr_beam_i) < NBEAMS);
  assign accept   = bus.commit_valid_i && ready_q;
  // The first idle cycle after reset starts an init load without any handshake.
  assign start    = accept || ((state_q == IDLE) && init_q);

  always_comb begin
    wr_hit = '0;
    if (wr_valid) wr_hit[bus.wr_beam_i] = 1'b1;
  end

  // A write colliding with the snapshot edge stays dirty: the snapshot took the old value.
  assign dirty_d = start ? wr_hit : (dirty_q | wr_hit);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    thresh_d = thresh_q;
    ce_d     = '0;
    update_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          idx_d    = '0;
          thresh_d = shadow_q[0];
          ce_d     = NBEAMS'(1);
        end
      end
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          state_d  = UPDATE;
          update_d = 1'b1;
        end else begin
          idx_d    = idx_q + 1'b1;
          thresh_d = snap_q[idx_d];
          ce_d     = NBEAMS'(1) << idx_d;
        end
      end
      UPDATE: begin
        state_d = SETTLE;
        done_d  = 1'b1;
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      init_q   <= 1'b1;
      dirty_q  <= '0;
      thresh_q <= '0;
      ce_q     <= '0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      for (int b = 0; b < NBEAMS; b++) begin
        shadow_q[b] <= RESET_THRESH;
        snap_q[b]   <= RESET_THRESH;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dirty_q  <= dirty_d;
      thresh_q <= thresh_d;
      ce_q     <= ce_d;
      update_q <= update_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      if (start) begin
        init_q <= 1'b0;
        for (int b = 0; b < NBEAMS; b++) snap_q[b] <= shadow_q[b];
      end
      if (wr_valid) shadow_q[bus.wr_beam_i] <= bus.wr_thresh_i;
    end
  end

  assign bus.commit_ready_o = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.dirty_o        = dirty_q;
  assign bus.thresh_o       = thresh_q;
  assign bus.thresh_ce_o    = ce_q;
  assign bus.update_o       = update_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_beam_threshold_sequencer.sv
// Directed bench for beam_threshold_sequencer: a 4-beam and a 3-beam instance on one clock.
module tb_beam_threshold_sequencer;
  import beam_ctrl_pkg::*;

  localparam int TB = 18;
  localparam logic [TB-1:0] RST_T = 18'h3FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [TB-1:0] exp_q[$];

  beam_threshold_sequencer_if #(.NBEAMS(4), .THRESH_BITS(TB)) bus4 ();
  beam_threshold_sequencer_if #(.NBEAMS(3), .THRESH_BITS(TB)) bus3 ();

  beam_threshold_sequencer #(.NBEAMS(4), .THRESH_BITS(TB), .RESET_THRESH(RST_T)) dut4 (
    .clk_i(clk), .rst_i(rst4), .bus(bus4)
  );
  beam_threshold_sequencer #(.NBEAMS(3), .THRESH_BITS(TB), .RESET_THRESH(RST_T)) dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(bus3)
  );

  typedef struct packed {
    logic          busy;
    logic          ready;
    logic          update;
    logic          done;
    logic [3:0]    ce;
    logic [3:0]    dirty;
    logic [TB-1:0] thresh;
  } obs_t;

  function automatic obs_t observe(input int w);
    obs_t o;
    if (w == 3) begin
      o.busy   = bus3.busy_o;
      o.ready  = bus3.commit_ready_o;
      o.update = bus3.update_o;
      o.done   = bus3.done_o;
      o.ce     = {1'b0, bus3.thresh_ce_o};
      o.dirty  = {1'b0, bus3.dirty_o};
      o.thresh = bus3.thresh_o;
    end else begin
      o.busy   = bus4.busy_o;
      o.ready  = bus4.commit_ready_o;
      o.update = bus4.update_o;
      o.done   = bus4.done_o;
      o.ce     = bus4.thresh_ce_o;
      o.dirty  = bus4.dirty_o;
      o.thresh = bus4.thresh_o;
    end
    return o;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int w, input logic en, input logic [1:0] beam, input logic [TB-1:0] val);
    if (w == 3) begin
      bus3.wr_en_i = en; bus3.wr_beam_i = beam; bus3.wr_thresh_i = val;
    end else begin
      bus4.wr_en_i = en; bus4.wr_beam_i = beam; bus4.wr_thresh_i = val;
    end
  endtask

  task automatic set_valid(input int w, input logic v);
    if (w == 3) bus3.commit_valid_i = v;
    else        bus4.commit_valid_i = v;
  endtask

  task automatic push_exp(input logic [TB-1:0] a, input logic [TB-1:0] b,
                          input logic [TB-1:0] c, input logic [TB-1:0] d, input int n);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    if (n > 3) exp_q.push_back(d);
  endtask

  // Called in the cycle right after the accept edge; ends in the first ready cycle.
  // Flags are packed as {busy, ready, update, done}.
  task automatic expect_seq(input int w, input int n, input int wr_at,
                            input logic [1:0] wr_b, input logic [TB-1:0] wr_v);
    obs_t o;
    logic [TB-1:0] e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      o = observe(w);
      e = exp_q.pop_front();
      check_eq($sformatf("dut%0d load%0d ce", w, i), 32'(o.ce), 32'(1) << i);
      check_eq($sformatf("dut%0d load%0d thresh", w, i), 32'(o.thresh), 32'(e));
      check_eq($sformatf("dut%0d load%0d flags", w, i),
               32'({o.busy, o.ready, o.update, o.done}), 32'(4'b1000));
      if (i == wr_at) drive_wr(w, 1'b1, wr_b, wr_v);
      step();
      if (i == wr_at) drive_wr(w, 1'b0, 2'd0, '0);
    end
    o = observe(w);
    check_eq($sformatf("dut%0d update flags", w), 32'({o.busy, o.ready, o.update, o.done}), 32'(4'b1010));
    check_eq($sformatf("dut%0d update ce", w), 32'(o.ce), 32'(0));
    check_eq($sformatf("dut%0d update thresh hold", w), 32'(o.thresh), 32'(e));
    step();
    o = observe(w);
    check_eq($sformatf("dut%0d settle flags", w), 32'({o.busy, o.ready, o.update, o.done}), 32'(4'b1001));
    check_eq($sformatf("dut%0d settle ce", w), 32'(o.ce), 32'(0));
    step();
    o = observe(w);
    check_eq($sformatf("dut%0d ready flags", w), 32'({o.busy, o.ready, o.update, o.done}), 32'(4'b0100));
  endtask

  task automatic check_reset_outputs(input int w, input string tag);
    obs_t o;
    o = observe(w);
    check_eq({tag, " flags"}, 32'({o.busy, o.ready, o.update, o.done}), 32'(0));
    check_eq({tag, " ce"}, 32'(o.ce), 32'(0));
    check_eq({tag, " thresh"}, 32'(o.thresh), 32'(0));
    check_eq({tag, " dirty"}, 32'(o.dirty), 32'(0));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    obs_t o;
    rst4 = 1'b1;
    rst3 = 1'b1;
    set_valid(4, 1'b0);
    set_valid(3, 1'b0);
    drive_wr(4, 1'b0, 2'd0, '0);
    drive_wr(3, 1'b0, 2'd0, '0);
    repeat (3) step();
    check_reset_outputs(4, "dut4 in reset");
    check_reset_outputs(3, "dut3 in reset");

    // Init sequence after reset release
    rst4 = 1'b0;
    step();
    push_exp(RST_T, RST_T, RST_T, RST_T, 4);
    expect_seq(4, 4, -1, 2'd0, '0);

    // Basic commit
    drive_wr(4, 1'b1, 2'd1, 18'h0A);
    step();
    drive_wr(4, 1'b1, 2'd0, 18'h14);
    step();
    drive_wr(4, 1'b0, 2'd0, '0);
    o = observe(4);
    check_eq("basic dirty before", 32'(o.dirty), 32'(4'b0011));
    set_valid(4, 1'b1);
    step();
    set_valid(4, 1'b0);
    o = observe(4);
    check_eq("basic dirty after", 32'(o.dirty), 32'(4'b0000));
    push_exp(18'h14, 18'h0A, RST_T, RST_T, 4);
    expect_seq(4, 4, -1, 2'd0, '0);

    // Write collides with accept: snapshot keeps old beam2
    set_valid(4, 1'b1);
    drive_wr(4, 1'b1, 2'd2, 18'h55);
    step();
    set_valid(4, 1'b0);
    drive_wr(4, 1'b0, 2'd0, '0);
    o = observe(4);
    check_eq("collision dirty", 32'(o.dirty), 32'(4'b0100));
    push_exp(18'h14, 18'h0A, RST_T, RST_T, 4);
    expect_seq(4, 4, -1, 2'd0, '0);

    // Next commit picks up 0x55; beam0 rewritten while LOAD is at idx 2
    set_valid(4, 1'b1);
    step();
    set_valid(4, 1'b0);
    o = observe(4);
    check_eq("second commit dirty", 32'(o.dirty), 32'(4'b0000));
    push_exp(18'h14, 18'h0A, 18'h55, RST_T, 4);
    expect_seq(4, 4, 2, 2'd0, 18'h99);
    o = observe(4);
    check_eq("busy write dirty", 32'(o.dirty), 32'(4'b0001));

    set_valid(4, 1'b1);
    step();
    set_valid(4, 1'b0);
    push_exp(18'h99, 18'h0A, 18'h55, RST_T, 4);
    expect_seq(4, 4, -1, 2'd0, '0);

    // Reset in the middle of LOAD
    drive_wr(4, 1'b1, 2'd3, 18'h77);
    step();
    drive_wr(4, 1'b0, 2'd0, '0);
    set_valid(4, 1'b1);
    step();
    set_valid(4, 1'b0);
    step();
    o = observe(4);
    check_eq("midload idx1 ce", 32'(o.ce), 32'(4'b0010));
    check_eq("midload idx1 thresh", 32'(o.thresh), 32'(18'h0A));
    rst4 = 1'b1;
    step();
    check_reset_outputs(4, "dut4 midload reset");
    rst4 = 1'b0;
    step();
    push_exp(RST_T, RST_T, RST_T, RST_T, 4);
    expect_seq(4, 4, -1, 2'd0, '0);

    // Three-beam instance: init, out-of-range write, held commit request
    rst3 = 1'b0;
    step();
    push_exp(RST_T, RST_T, RST_T, RST_T, 3);
    expect_seq(3, 3, -1, 2'd0, '0);
    drive_wr(3, 1'b1, 2'd3, 18'h123);
    step();
    drive_wr(3, 1'b0, 2'd0, '0);
    o = observe(3);
    check_eq("nb3 oob dirty", 32'(o.dirty), 32'(0));
    drive_wr(3, 1'b1, 2'd1, 18'h21);
    step();
    drive_wr(3, 1'b0, 2'd0, '0);
    o = observe(3);
    check_eq("nb3 write dirty", 32'(o.dirty), 32'(3'b010));
    set_valid(3, 1'b1);
    step();
    o = observe(3);
    check_eq("nb3 dirty after accept", 32'(o.dirty), 32'(0));
    push_exp(RST_T, 18'h21, RST_T, RST_T, 3);
    expect_seq(3, 3, -1, 2'd0, '0);
    step();
    set_valid(3, 1'b0);
    push_exp(RST_T, 18'h21, RST_T, RST_T, 3);
    expect_seq(3, 3, -1, 2'd0, '0);
    step();
    o = observe(3);
    check_eq("nb3 idle after release", 32'({o.busy, o.ready, o.update, o.done}), 32'(4'b0100));
    check_eq("nb3 idle ce", 32'(o.ce), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/beam_threshold_sequencer.md
# beam_threshold_sequencer

Threshold configuration controller for `beam_alignment`. It holds a per-beam shadow threshold register file written from the control side. On a commit handshake it snapshots the file and walks every beam, driving `thresh_i`/`thresh_ce_i` one beam per cycle, then issues the single `update_i` pulse that makes the new thresholds live atomically. It sits between the register/AXI-lite decode and the `beam_alignment` instance; its outputs connect directly to that instance's threshold ports.

## Interface
- `NBEAMS`, 4, number of beams; width of the CE and dirty vectors.
- `THRESH_BITS`, 18, threshold width; matches `beam_alignment` `thresh_i`.
- `RESET_THRESH`, 18'h3FFFF, shadow and snapshot value after reset (max threshold, so no triggers).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock, the same clock as `beam_alignment`.
- `rst_i`  in  1  synchronous active-high reset.
- `wr_en_i`  in  1  shadow write strobe.
- `wr_beam_i`  in  `$clog2(NBEAMS)`  beam index for the write; writes with index ≥ NBEAMS are ignored.
- `wr_thresh_i`  in  `THRESH_BITS`  shadow write data.
- `commit_valid_i`  in  1  request to load the shadow file into the datapath.
- `commit_ready_o`  out  1  high only in IDLE; a commit is accepted when valid and ready are both high at a rising edge.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when a load sequence completes.
- `dirty_o`  out  `NBEAMS`  per beam: the shadow value differs from what was last loaded, or has been written since the last snapshot.
- `thresh_o`  out  `THRESH_BITS`  connects to `beam_alignment.thresh_i`.
- `thresh_ce_o`  out  `NBEAMS`  connects to `thresh_ce_i`; bit b loads beam b.
- `update_o`  out  1  connects to `update_i`.

## Operation
- **Shadow writes.** A write with `wr_en_i` and a valid index updates `shadow[wr_beam_i]` and sets `dirty[wr_beam_i]`. Writes are accepted in every state.
- **Commit acceptance.** On accept, all shadow entries are copied into the snapshot and `dirty` is cleared.
  - If a write arrives in the same cycle as the accept, the snapshot takes the pre-write value and that beam's dirty bit ends the cycle set.
- **FSM states:** IDLE, LOAD, UPDATE, SETTLE.
  - IDLE → LOAD on accept.
  - LOAD runs `idx` from 0 to NBEAMS-1 with `thresh_o=snap[idx]` and `thresh_ce_o=1<<idx`. It exits to UPDATE after `idx==NBEAMS-1`.
  - UPDATE lasts one cycle: `update_o=1`, `thresh_ce_o=0`.
  - SETTLE lasts one cycle and covers the datapath's second apply clock: `done_o=1`. It returns to IDLE.
- **Datapath-facing outputs.** All of them are registered.
  - `thresh_o` holds its last value outside LOAD.
  - `thresh_ce_o` and `update_o` are 0 outside LOAD and UPDATE respectively.
- **Arithmetic.** `idx` is an unsigned counter of `$clog2(NBEAMS)` bits, with a terminal compare at NBEAMS-1. It works for non-power-of-2 NBEAMS with no wrap dependency.
- **Writes during busy.** They modify the shadow only. The in-flight sequence uses the snapshot; the new values take effect on the next commit.

## Timing
- **While `rst_i` is high.** All outputs are 0, including `commit_ready_o` and `busy_o`. `thresh_o` is 0. Shadow and snapshot are set to RESET_THRESH and `dirty` is cleared.
- **After reset.** On the first cycle after `rst_i` falls, the FSM enters LOAD automatically: an init commit of RESET_THRESH without a handshake. So `beam_alignment` never runs with undefined thresholds.
- **Commit latency.** For an accept at edge T:
  - cycles T+1 … T+NBEAMS carry the CE one-hot;
  - T+NBEAMS+1 carries `update_o`;
  - T+NBEAMS+2 carries `done_o`;
  - `commit_ready_o` rises at T+NBEAMS+3.
- **Throughput.** One commit per NBEAMS+3 cycles.
- **Held request.** `commit_valid_i` held high continuously produces back-to-back commits with one IDLE cycle between them.
- **Reset mid-sequence.** It aborts the sequence and does not emit `update_o` or `done_o`. The previously live datapath thresholds persist until the init sequence's update pulse.
- **`busy_o`.** High from T+1 through the SETTLE cycle inclusive.

## Structure
- Package `beam_ctrl_pkg` holds:
  - the `bts_state_t` enum (IDLE, LOAD, UPDATE, SETTLE);
  - the default `THRESH_BITS`;
  - a `BEAM_IDX_W(n)` width function shared with `beam_alignment` and its register decode.
- Single module, no sub-modules. The shadow and snapshot are flop arrays (NBEAMS×THRESH_BITS each), not BRAM.

## Test plan
- **Reset/init.** Deassert `rst_i` and capture `thresh_ce_o` sequence 0001, 0010, 0100, 1000 with `thresh_o`=0x3FFFF each cycle → then `update_o` one cycle, then `done_o`, then `commit_ready_o`=1.
- **Basic commit.** Write beam1=0x0A and beam0=0x14, then commit → `dirty_o`=0011 before the accept and 0000 after. Captured thresholds are [0x14, 0x0A, 0x3FFFF, 0x3FFFF]. `update_o` fires exactly NBEAMS+1 cycles after the accept.
- **Collision.** Write beam2=0x55 in the same cycle as the accept, while the old beam2 value is 0x3FFFF → LOAD drives 0x3FFFF for beam2. `dirty_o`=0100 after the accept. The next commit drives 0x55.
- **Write during busy.** Write beam0=0x99 during LOAD idx=2 → the current sequence is unaffected. `dirty_o`[0]=1. `commit_ready_o` stays low until T+NBEAMS+3.
- **Reset mid-LOAD.** Assert `rst_i` at idx=1 → the next-cycle outputs are all 0, no `update_o` is emitted, and a fresh RESET_THRESH init sequence follows.
- **Out-of-range index.** Run with NBEAMS=3 and write index 3 → ignored, with `dirty_o` unchanged. Hold `commit_valid_i` high → two back-to-back sequences separated by one ready cycle.
